// File: rtl/io_request_arbiter.sv
// io_request_arbiter: holds one I/O request per core and serializes them round-robin onto a single register bus
module io_request_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int THREADS_PER_CORE = 4,
    localparam int TIDW = THREADS_PER_CORE > 1 ? $clog2(THREADS_PER_CORE) : 1,
    localparam int IW   = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] ioreq_valid,
    input  logic [NUM_CORES-1:0] ioreq_store,
    input  logic [TIDW-1:0]      ioreq_thread_idx [NUM_CORES],
    input  logic [31:0]          ioreq_address [NUM_CORES],
    input  logic [31:0]          ioreq_value [NUM_CORES],
    output logic [NUM_CORES-1:0] ioreq_ready,
    output logic                 iorsp_valid,
    output logic [3:0]           iorsp_core,
    output logic [TIDW-1:0]      iorsp_thread_idx,
    output logic [31:0]          iorsp_read_value,
    output logic                 io_write_en,
    output logic                 io_read_en,
    output logic [31:0]          io_address,
    output logic [31:0]          io_write_data,
    input  logic [31:0]          io_read_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    localparam logic [IW:0] NC = (IW+1)'(NUM_CORES);

    state_t               state, state_next;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] slot_store;
    logic [TIDW-1:0]      slot_tid [NUM_CORES];
    logic [31:0]          slot_addr [NUM_CORES];
    logic [31:0]          slot_value [NUM_CORES];
    logic [IW-1:0]        rr_ptr, grant, pick;
    logic [IW:0]          idx;
    logic                 start;

    assign ioreq_ready = ~pending;
    assign start       = state == IDLE && |pending;

    // first pending slot at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx  = {1'b0, rr_ptr} + (IW+1)'(k);
            idx  = idx >= NC ? idx - NC : idx;
            pick = pending[idx[IW-1:0]] ? idx[IW-1:0] : pick;
        end
    end

    // fixed four-phase transaction sequence, leaving IDLE only when something is pending
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = |pending ? ISSUE : IDLE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // request slots, grant/pointer bookkeeping, registered bus strobes and response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending          <= '0;
            slot_store       <= '0;
            rr_ptr           <= '0;
            grant            <= '0;
            io_write_en      <= 1'b0;
            io_read_en       <= 1'b0;
            io_address       <= '0;
            io_write_data    <= '0;
            iorsp_valid      <= 1'b0;
            iorsp_core       <= '0;
            iorsp_thread_idx <= '0;
            iorsp_read_value <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_tid[i]   <= '0;
                slot_addr[i]  <= '0;
                slot_value[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (ioreq_valid[i] && !pending[i]) begin
                    pending[i]    <= 1'b1;
                    slot_store[i] <= ioreq_store[i];
                    slot_tid[i]   <= ioreq_thread_idx[i];
                    slot_addr[i]  <= ioreq_address[i];
                    slot_value[i] <= ioreq_value[i];
                end
            end
            io_write_en <= start && slot_store[pick];
            io_read_en  <= start && !slot_store[pick];
            if (start) begin
                grant         <= pick;
                io_address    <= slot_addr[pick];
                io_write_data <= slot_store[pick] ? slot_value[pick] : '0;
            end
            iorsp_valid <= state == WAIT;
            if (state == WAIT) begin
                iorsp_core       <= 4'(grant);
                iorsp_thread_idx <= slot_tid[grant];
                iorsp_read_value <= slot_store[grant] ? '0 : io_read_data;
            end
            if (state == RESPOND) begin
                pending[grant] <= 1'b0;
                rr_ptr         <= grant == IW'(NUM_CORES - 1) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule
